// File: rtl/arith_unit_pipe.sv
// Registered add/subtract unit: eight opcodes, carry chaining, signed saturation,
// an internal accumulator and status flags behind valid/ready handshakes (latency 1).
module arith_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_ADC     = 3'b010,
        OP_SBB     = 3'b011,
        OP_ACC_ADD = 3'b100,
        OP_ACC_CLR = 3'b101,
        OP_SADD    = 3'b110,
        OP_SSUB    = 3'b111
    } opcode_e;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;
    logic [WIDTH-1:0] r_acc;
    logic             r_cf;

    opcode_e          w_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
    logic             w_isSub;
    logic             w_cin;
    logic [WIDTH:0]   w_uWide;
    logic [WIDTH:0]   w_sWide;
    logic [WIDTH-1:0] w_raw;
    logic             w_rawOverflow;
    logic [WIDTH-1:0] w_final;
    logic             w_carry;
    logic             w_overflow;

    assign w_op     = opcode_e'(op);
    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Unsigned and sign-extended datapaths share operands; the signed one yields true overflow even with carry-in.
    always_comb begin
        w_opA   = (w_op == OP_ACC_ADD) ? r_acc : a;
        w_opB   = (w_op == OP_ACC_ADD) ? a : b;
        w_isSub = (w_op == OP_SUB) || (w_op == OP_SBB) || (w_op == OP_SSUB);
        w_cin   = ((w_op == OP_ADC) || (w_op == OP_SBB)) ? r_cf : 1'b0;
        if (w_isSub) begin
            w_uWide = {1'b0, w_opA} - {1'b0, w_opB} - {{WIDTH{1'b0}}, w_cin};
            w_sWide = {w_opA[WIDTH-1], w_opA} - {w_opB[WIDTH-1], w_opB} - {{WIDTH{1'b0}}, w_cin};
        end else begin
            w_uWide = {1'b0, w_opA} + {1'b0, w_opB} + {{WIDTH{1'b0}}, w_cin};
            w_sWide = {w_opA[WIDTH-1], w_opA} + {w_opB[WIDTH-1], w_opB} + {{WIDTH{1'b0}}, w_cin};
        end
        w_raw         = w_uWide[WIDTH-1:0];
        w_rawOverflow = w_sWide[WIDTH] ^ w_sWide[WIDTH-1];
    end

    always_comb begin
        w_final    = w_raw;
        w_carry    = w_uWide[WIDTH];
        w_overflow = w_rawOverflow;
        case (w_op)
            OP_ACC_CLR: begin
                w_final    = '0;
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
            OP_SADD, OP_SSUB: begin
                // Overflow direction follows operand A's sign for both add and subtract.
                if (w_rawOverflow) begin
                    w_final = w_opA[WIDTH-1] ? SMIN : SMAX;
                end
            end
            default: begin
                w_final = w_raw;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_acc      <= '0;
            r_cf       <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_result   <= w_final;
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
            r_zero     <= (w_final == '0);
            r_negative <= w_final[WIDTH-1];
            r_cf       <= w_carry;
            if (w_op == OP_ACC_ADD) begin
                r_acc <= w_final;
            end else if (w_op == OP_ACC_CLR) begin
                r_acc <= '0;
            end
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign acc       = r_acc;

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Directed testbench for arith_unit_pipe (WIDTH=8) with hand-computed expected values.
module tb_arith_unit_pipe;

    localparam int WIDTH = 8;
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_ADC     = 3'b010;
    localparam logic [2:0] OP_SBB     = 3'b011;
    localparam logic [2:0] OP_ACC_ADD = 3'b100;
    localparam logic [2:0] OP_ACC_CLR = 3'b101;
    localparam logic [2:0] OP_SADD    = 3'b110;
    localparam logic [2:0] OP_SSUB    = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic [WIDTH-1:0] acc;

    int testsRun = 0;
    int testsFailed = 0;
    int deliveredCount = 0;
    int baseDelivered;

    arith_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    // Counts every completed output handshake.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            deliveredCount <= deliveredCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation, waits for its accept and leaves the result unconsumed.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int waitCycles;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b0;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("inReady", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("outValidLatency", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] expResult, input logic expCarry, input logic expOverflow);
        logic expZero;
        logic expNegative;
        expZero = (expResult == 8'h00);
        expNegative = expResult[7];
        applyStimulus(o, x, y);
        checkOutput({tag, ".result"}, {24'b0, result}, {24'b0, expResult});
        checkOutput({tag, ".carry"}, {31'b0, carry}, {31'b0, expCarry});
        checkOutput({tag, ".overflow"}, {31'b0, overflow}, {31'b0, expOverflow});
        checkOutput({tag, ".zero"}, {31'b0, zero}, {31'b0, expZero});
        checkOutput({tag, ".negative"}, {31'b0, negative}, {31'b0, expNegative});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".drain"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.outValid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset.inReady", {31'b0, in_ready}, 32'd1);
        checkOutput("reset.result", {24'b0, result}, 32'd0);
        checkOutput("reset.acc", {24'b0, acc}, 32'd0);
        checkOutput("reset.zero", {31'b0, zero}, 32'd0);
        rst_n = 1'b1;

        runOp("add7F01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        runOp("sub0506", OP_SUB, 8'h05, 8'h06, 8'hFF, 1'b1, 1'b0);
        runOp("sub0A08", OP_SUB, 8'h0A, 8'h08, 8'h02, 1'b0, 1'b0);

        runOp("addFF01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        runOp("adcCf1", OP_ADC, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        runOp("sbbCf0", OP_SBB, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        runOp("sub0001", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        runOp("sbbCf1", OP_SBB, 8'h05, 8'h01, 8'h03, 1'b0, 1'b0);

        runOp("sadd7F01", OP_SADD, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1);
        runOp("ssub8001", OP_SSUB, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1);
        runOp("sadd1020", OP_SADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
        runOp("sadd80FF", OP_SADD, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b1);
        runOp("ssub7FFF", OP_SSUB, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b1);

        runOp("accClr", OP_ACC_CLR, 8'h33, 8'h44, 8'h00, 1'b0, 1'b0);
        checkOutput("accClr.acc", {24'b0, acc}, 32'h00);
        runOp("accAdd1", OP_ACC_ADD, 8'h10, 8'h55, 8'h10, 1'b0, 1'b0);
        checkOutput("accAdd1.acc", {24'b0, acc}, 32'h10);
        runOp("accAdd2", OP_ACC_ADD, 8'h10, 8'hAA, 8'h20, 1'b0, 1'b0);
        checkOutput("accAdd2.acc", {24'b0, acc}, 32'h20);
        runOp("accAdd3", OP_ACC_ADD, 8'h10, 8'h00, 8'h30, 1'b0, 1'b0);
        checkOutput("accAdd3.acc", {24'b0, acc}, 32'h30);

        applyStimulus(OP_ADD, 8'h03, 8'h02);
        op = OP_ADD;
        a = 8'h01;
        b = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall.inReady", {31'b0, in_ready}, 32'd0);
            checkOutput("stall.outValid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall.result", {24'b0, result}, 32'h05);
            checkOutput("stall.acc", {24'b0, acc}, 32'h30);
        end
        baseDelivered = deliveredCount;
        out_ready = 1'b1;
        #1;
        checkOutput("stall.inReadyRelease", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("stall.nextValid", {31'b0, out_valid}, 32'd1);
        checkOutput("stall.nextResult", {24'b0, result}, 32'h02);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("stall.drained", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("stall.delivered", deliveredCount - baseDelivered, 32'd2);
        checkOutput("stall.accAfter", {24'b0, acc}, 32'h30);

        applyStimulus(OP_ACC_ADD, 8'hF0, 8'h00);
        checkOutput("preReset.result", {24'b0, result}, 32'h20);
        checkOutput("preReset.carry", {31'b0, carry}, 32'd1);
        checkOutput("preReset.acc", {24'b0, acc}, 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.outValid", {31'b0, out_valid}, 32'd0);
        checkOutput("midReset.acc", {24'b0, acc}, 32'd0);
        checkOutput("midReset.result", {24'b0, result}, 32'd0);
        checkOutput("midReset.carry", {31'b0, carry}, 32'd0);
        checkOutput("midReset.overflow", {31'b0, overflow}, 32'd0);
        checkOutput("midReset.zero", {31'b0, zero}, 32'd0);
        checkOutput("midReset.negative", {31'b0, negative}, 32'd0);
        checkOutput("midReset.inReady", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("adcAfterReset", OP_ADC, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/arith_unit_pipe.md
Name: arith_unit_pipe

Overview:
Parametrised, registered add/subtract unit with an 8-opcode set. It supports carry-chained multi-word arithmetic, signed saturation, an internal accumulator and full status flags. Operands enter through a valid/ready handshake and results leave through one, with one cycle of latency and full backpressure. It is the general-purpose arithmetic datapath block for team designs, replacing fixed-width combinational add/sub.

Parameters:
WIDTH, 8, operand/result width in bits (legal range >= 2)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  unit can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  opcode (see Behaviour)
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream accepts result
result  output  WIDTH  result
carry  output  1  unsigned carry-out (add) or borrow (sub)
overflow  output  1  signed overflow; for saturating ops, 1 = result was clamped
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
acc  output  WIDTH  current accumulator value (live register, not handshaked)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, result=0, carry=0, overflow=0, zero=0, negative=0, acc=0, internal carry flag cf=0. in_ready=1 while out_valid=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, result/flags are registered and out_valid=1 next cycle (latency 1).
  - If out_valid && out_ready && !accept, out_valid clears to 0.
  - While out_valid && !out_ready, result and all flags hold stable.
  - Simultaneous consume and accept: the new result loads and out_valid stays 1. No bubble, no loss, no duplicate.
- Opcodes (all arithmetic is modulo 2^WIDTH; carry taken from the WIDTH+1-bit sum):
  - 000 ADD: a+b. carry=carry-out. overflow = a,b same sign and result sign differs.
  - 001 SUB: a-b. carry=borrow (1 iff a<b unsigned). overflow = a,b signs differ and result sign differs from a.
  - 010 ADC: a+b+cf. Flags as ADD.
  - 011 SBB: a-b-cf. carry=borrow of the full subtraction. Flags as SUB.
  - 100 ACC_ADD: result = acc+a. acc <= result. Flags as ADD with acc as first operand; b is ignored.
  - 101 ACC_CLR: acc <= 0, result=0, carry=0, overflow=0, zero=1, negative=0.
  - 110 SADD: signed a+b. On signed overflow, clamp to max positive 0111..1 or min negative 1000..0 and set overflow=1. carry = unsaturated carry-out.
  - 111 SSUB: signed a-b, clamped as SADD. overflow=1 iff clamped. carry = unsaturated borrow.
- Carry flag cf:
  - Every accepted op sets cf <= that op's carry output.
  - ADC/SBB use the cf value from before the current accept, i.e. from the previous accepted op.
- zero and negative are always computed on the final (post-clamp) result.
- acc changes only on an accepted ACC_ADD or ACC_CLR. It never changes while stalled.
- Reset mid-operation discards any pending result immediately. No partial state survives.
- Inputs are sampled only on accept. Values present while in_ready=0 are don't-care.

Test Plan:
- ADD a=0x7F b=0x01 -> result=0x80, carry=0, overflow=1, negative=1, zero=0, out_valid one cycle after accept.
- SUB a=0x05 b=0x06 -> result=0xFF, carry=1, overflow=0, negative=1. SUB a=0x0A b=0x08 -> 0x02, carry=0.
- Carry chain:
  - ADD 0xFF+0x01 -> 0x00, carry=1, zero=1.
  - Then ADC 0x00+0x00 -> 0x01, carry=0.
  - Then SBB 0x00-0x00 with cf=0 -> 0x00. SUB 0x00-0x01 -> 0xFF, carry=1.
  - Then SBB 0x05-0x01 -> 0x03.
- Saturation: SADD 0x7F+0x01 -> 0x7F, overflow=1, carry=0. SSUB 0x80-0x01 -> 0x80, overflow=1, carry=0. SADD 0x10+0x20 -> 0x30, overflow=0.
- Backpressure:
  - Accept ADD 0x03+0x02. Hold out_ready=0 for 3 cycles while in_valid=1 with ADD 0x01+0x01.
  - Required: in_ready=0, result=0x05 stable, acc/cf unchanged.
  - Raise out_ready: 0x05 consumed and 0x01+0x01 accepted the same cycle, then 0x02 next cycle. Exactly two results delivered.
- Accumulator/reset:
  - ACC_CLR, then ACC_ADD a=0x10 three times -> results 0x10, 0x20, 0x30, acc=0x30.
  - Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, acc=0, all flags 0 immediately (asynchronous).
